gf180mcu_fd_sc_mcu7t5v0__nandn_pipe: RTL
========================================

GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__nandn_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the inputs per channel; legal range 2..81.
REQ-002 The block SHALL have parameter CH, default 4, giving the number of independent channels; legal range 1..16.
REQ-003 The block SHALL have parameter INVERT, default 1: 1 = NAND output, 0 = AND output.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; the ports SHALL be named CLK and RN.
REQ-005 The block SHALL have port CLK, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port RN, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port EN, input, 1 bit: pipeline advance; 0 = every stage holds.
REQ-008 The block SHALL have port VLD_IN, input, 1 bit: A carries a valid vector this cycle.
REQ-009 The block SHALL have port A, input, CH*WIDTH bits: channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 The block SHALL have port ZN, output, CH bits: the registered per-channel result.
REQ-011 The block SHALL have port VLD_OUT, output, 1 bit: ZN holds a valid result.
REQ-012 Under USE_POWER_PINS, the block SHALL add inout ports VDD and VSS; they SHALL be otherwise unused.

Function
REQ-013 Each channel SHALL reduce its inputs through a tree of 3-input AND nodes.
- Tree depth L = ceil(log3(WIDTH)), so L=1 for WIDTH 2..3, L=2 for 4..9, L=3 for 10..27, L=4 for 28..81.
REQ-014 At every tree level, missing leaf positions SHALL be padded with logic 1.
REQ-015 There SHALL be exactly one register rank per tree level; the last rank is the output register driving ZN.
REQ-016 INVERT SHALL be applied combinationally before the output register.
- ZN[c] = INVERT ? ~&A_c : &A_c, delayed by L enabled edges.
REQ-017 Latency SHALL be exactly L rising CLK edges with EN=1, from the edge sampling A to the edge updating ZN.
- Edges with EN=0 SHALL NOT count towards latency.
REQ-018 A valid bit SHALL travel alongside each register rank.
- VLD_OUT SHALL assert exactly when the result derived from a VLD_IN=1 sample reaches ZN.
REQ-019 Data ranks SHALL capture on every enabled edge, regardless of VLD_IN.
- ZN content is unspecified whenever VLD_OUT=0.
REQ-020 With EN=0, all data ranks, all valid bits, ZN and VLD_OUT SHALL hold their values.
- A and VLD_IN SHALL be ignored on those edges.
REQ-021 With EN=1 every cycle, the block SHALL accept a new vector on every edge (throughput 1 per cycle).
- Results SHALL emerge in input order, with no bubbles other than those present on VLD_IN.
REQ-022 Channels SHALL be fully independent; they SHALL share only EN and the valid pipeline.
REQ-023 There SHALL be no combinational path from any input to ZN or VLD_OUT.

Reset
REQ-024 While RN=0, ZN, VLD_OUT, all intermediate data ranks and all valid bits SHALL be forced to 0 asynchronously, independent of CLK and EN.
REQ-025 When RN is asserted mid-operation, all in-flight vectors SHALL be discarded.
- The first VLD_OUT=1 after release SHALL come from a vector sampled after release.
REQ-026 Release of RN SHALL take effect on the next rising CLK edge.
- The first edge with RN=1 and EN=1 SHALL sample A normally.

Verification
REQ-027 The bench SHALL cover the basic NAND case:
- Stimulus: WIDTH=9, CH=4, INVERT=1, EN=1; A_c all ones for c=0, and 9'h1FE for c=1..3, VLD_IN=1 for one cycle.
- Required: after 2 edges, ZN=4'b1110 and VLD_OUT=1 for exactly one cycle.
REQ-028 The bench SHALL cover the stall case:
- Stimulus: same configuration, with EN=0 held for 3 cycles between the two enabled edges.
- Required: ZN and VLD_OUT unchanged during the stall; the result appears on the 2nd enabled edge.
REQ-029 The bench SHALL cover back-to-back vectors:
- Stimulus: WIDTH=10 (L=3), INVERT=0, 8 consecutive valid random vectors.
- Required: 8 consecutive VLD_OUT=1 cycles starting at the 3rd edge, each ZN matching the &-reference in order.
REQ-030 The bench SHALL cover padding:
- Stimulus: WIDTH=2, CH=1, INVERT=1; A=2'b11, then A=2'b01.
- Required: L=1; ZN=0, then ZN=1 on consecutive edges.
REQ-031 The bench SHALL cover reset mid-flight:
- Stimulus: WIDTH=27, pulse RN low asynchronously between edges while 2 vectors are in flight.
- Required: ZN=0 and VLD_OUT=0 immediately; no VLD_OUT until 3 edges after a new VLD_IN=1.
REQ-032 The bench SHALL cover the width limit:
- Stimulus: WIDTH=81, CH=16, with a single 0 at bit 80 of channel 15.
- Required: L=4; only ZN[15]=1 with INVERT=1.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pipe.sv
// Pipelined multi-channel wide NAND/AND.
// Each channel reduces WIDTH inputs through a tree of 3-input AND nodes.
// Leaves are padded with logic 1 up to 3**L positions.
// Every tree level is one register rank, and the last rank drives ZN.
// A valid bit travels alongside each rank.
// EN stalls every rank, including the valid pipeline.
module gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(
  parameter int WIDTH  = 9,
  parameter int CH     = 4,
  parameter bit INVERT = 1'b1
) (
`ifdef USE_POWER_PINS
  inout  wire                  VDD,
  inout  wire                  VSS,
`endif
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 EN,
  input  logic                 VLD_IN,
  input  logic [CH*WIDTH-1:0]  A,
  output logic [CH-1:0]        ZN,
  output logic                 VLD_OUT
);

  // Smallest L such that 3**L >= n.
  function automatic int clog3(input int n);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * 3;
      l = l + 1;
    end
    return l;
  endfunction

  function automatic int pow3(input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) begin
      p = p * 3;
    end
    return p;
  endfunction

  localparam int L        = clog3(WIDTH);
  localparam int LEAVES   = pow3(L);
  // Rank k holds CH * 3**(L-1-k) nodes; all ranks are packed into one vector.
  localparam int TOTAL    = CH * (LEAVES - 1) / 2;
  localparam int OUT_BASE = TOTAL - CH;

  // Bit offset of rank k inside the packed tree vector.
  function automatic int rank_base(input int k);
    int b;
    b = 0;
    for (int j = 0; j < k; j++) begin
      b = b + CH * pow3(L - 1 - j);
    end
    return b;
  endfunction

  logic [TOTAL-1:0] tree_r;
  logic [TOTAL-1:0] tree_d;
  logic [L-1:0]     vld_r;
  logic [L-1:0]     vld_d;
  logic [2:0]       leg_s;

  // Next value of every tree node.
  // Rank 0 reads padded leaves from A, and higher ranks read the previous rank.
  // The output polarity is applied ahead of the last rank.
  always_comb begin
    tree_d = '0;
    leg_s  = 3'b111;
    for (int k = 0; k < L; k++) begin
      for (int c = 0; c < CH; c++) begin
        for (int n = 0; n < pow3(L - 1 - k); n++) begin
          for (int j = 0; j < 3; j++) begin
            if (k == 0) begin
              if ((3 * n + j) < WIDTH) begin
                leg_s[j] = A[c * WIDTH + 3 * n + j];
              end else begin
                leg_s[j] = 1'b1;
              end
            end else begin
              leg_s[j] = tree_r[rank_base(k - 1) + c * 3 * pow3(L - 1 - k) + 3 * n + j];
            end
          end
          tree_d[rank_base(k) + c * pow3(L - 1 - k) + n] =
            ((k == L - 1) && INVERT) ? ~(&leg_s) : (&leg_s);
        end
      end
    end
  end

  // Next value of the valid pipeline: a plain shift alongside the data ranks.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = VLD_IN;
    for (int k = 1; k < L; k++) begin
      vld_d[k] = vld_r[k - 1];
    end
  end

  // Register all ranks: clear asynchronously, advance on EN, otherwise hold.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      tree_r <= '0;
      vld_r  <= '0;
    end else if (EN) begin
      tree_r <= tree_d;
      vld_r  <= vld_d;
    end else begin
      tree_r <= tree_r;
      vld_r  <= vld_r;
    end
  end

  assign ZN      = tree_r[OUT_BASE +: CH];
  assign VLD_OUT = vld_r[L-1];

endmodule
